// File: rtl/spi_master_driver.sv
// spi_master_driver: single-clock SPI master that issues 11-bit command frames
// to the SPI slave/RAM wrapper and captures the byte returned for read-data frames.
module spi_master_driver #(
  parameter int unsigned RD_WAIT    = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       cmd_err,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int unsigned WORD_W = 11;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [2:0] CMD_WR_ADDR = 3'b000;
  localparam logic [2:0] CMD_WR_DATA = 3'b001;
  localparam logic [2:0] CMD_RD_ADDR = 3'b110;
  localparam logic [2:0] CMD_RD_DATA = 3'b111;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RECV  = 3'd4,
    ST_END   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [BYTE_W-1:0]   shreg_q, shreg_d;
  logic [BYTE_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic                cmd_err_q, cmd_err_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                ss_n_q, ss_n_d;
  logic                mosi_q, mosi_d;
  logic                cmd_legal;

  assign cmd_legal = (req_cmd == CMD_WR_ADDR) || (req_cmd == CMD_WR_DATA) ||
                     (req_cmd == CMD_RD_ADDR) || (req_cmd == CMD_RD_DATA);

  // State register and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      shreg_q      <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      ss_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      shreg_q      <= shreg_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      cmd_err_q    <= cmd_err_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      ss_n_q       <= ss_n_d;
      mosi_q       <= mosi_d;
    end
  end

  // Next-state logic; pin values are derived from the next state so they register cleanly.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    shreg_d      = shreg_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    cmd_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (cmd_legal) begin
            word_d  = {req_cmd, req_data};
            state_d = ST_START;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_START: begin
        state_d = ST_SHIFT;
        cnt_d   = SHIFT_LAST;
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          if (word_q[WORD_W-1 -: 3] == CMD_RD_DATA) begin
            if (RD_WAIT == 0) begin
              state_d = ST_RECV;
              cnt_d   = RECV_LAST;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_LOAD;
            end
          end else begin
            state_d = ST_END;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RECV;
          cnt_d   = RECV_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RECV: begin
        shreg_d = {shreg_q[BYTE_W-2:0], MISO};
        if (cnt_q == '0) begin
          state_d      = ST_END;
          cnt_d        = GAP_LOAD;
          resp_data_d  = shreg_d;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_END: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ss_n_d      = !((state_d == ST_START) || (state_d == ST_SHIFT) ||
                    (state_d == ST_WAIT)  || (state_d == ST_RECV));
    mosi_d      = (state_d == ST_SHIFT) ? word_d[cnt_d] : 1'b0;
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign cmd_err    = cmd_err_q;
  assign busy       = busy_q;
  assign SS_n       = ss_n_q;
  assign MOSI       = mosi_q;

endmodule
